// File: rtl/conv_window_reader.sv
// Snapshots a 4x4 input tile and a 3x3 filter. Computes the four valid 3x3
// convolution windows with one multiplier and streams the sums over valid/ready.
module conv_window_reader #(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [16*DW-1:0]   input_bus,
  input  logic [9*DW-1:0]    filter_bus,
  output logic               busy,
  output logic [AW-1:0]      out_data,
  output logic [1:0]         out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_r;
  logic [DW-1:0]   in_snap_r   [16];
  logic [DW-1:0]   filt_snap_r [9];
  logic [AW-1:0]   acc_r;
  logic [3:0]      k_r;
  logic [1:0]      w_r;
  logic [AW-1:0]   out_data_r;
  logic [1:0]      out_idx_r;
  logic            out_valid_r;
  logic            done_r;
  logic            busy_r;

  logic [1:0]      tap_row_s;
  logic [1:0]      tap_col_s;
  logic [1:0]      pix_row_s;
  logic [1:0]      pix_col_s;
  logic [3:0]      pix_idx_s;
  logic [DW-1:0]   pix_s;
  logic [DW-1:0]   filt_s;
  logic [2*DW-1:0] prod_s;
  logic [AW-1:0]   sum_s;

  // Split tap index k into filter row k/3 and column k%3
  always_comb begin
    tap_row_s = 2'd0;
    tap_col_s = 2'd0;
    case (k_r)
      4'd0:    begin tap_row_s = 2'd0; tap_col_s = 2'd0; end
      4'd1:    begin tap_row_s = 2'd0; tap_col_s = 2'd1; end
      4'd2:    begin tap_row_s = 2'd0; tap_col_s = 2'd2; end
      4'd3:    begin tap_row_s = 2'd1; tap_col_s = 2'd0; end
      4'd4:    begin tap_row_s = 2'd1; tap_col_s = 2'd1; end
      4'd5:    begin tap_row_s = 2'd1; tap_col_s = 2'd2; end
      4'd6:    begin tap_row_s = 2'd2; tap_col_s = 2'd0; end
      4'd7:    begin tap_row_s = 2'd2; tap_col_s = 2'd1; end
      4'd8:    begin tap_row_s = 2'd2; tap_col_s = 2'd2; end
      default: begin tap_row_s = 2'd0; tap_col_s = 2'd0; end
    endcase
  end

  // Window index w is {wr, wc}; the offsets never exceed 3, so 2 bits suffice
  assign pix_row_s = tap_row_s + {1'b0, w_r[1]};
  assign pix_col_s = tap_col_s + {1'b0, w_r[0]};
  assign pix_idx_s = {pix_row_s, pix_col_s};
  assign pix_s     = in_snap_r[pix_idx_s];
  assign filt_s    = filt_snap_r[k_r];
  assign prod_s    = {{DW{1'b0}}, pix_s} * {{DW{1'b0}}, filt_s};
  assign sum_s     = acc_r + {{(AW-2*DW){1'b0}}, prod_s};

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= '0;
      k_r         <= 4'd0;
      w_r         <= 2'd0;
      out_data_r  <= '0;
      out_idx_r   <= 2'd0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < 16; i++) in_snap_r[i] <= '0;
      for (int i = 0; i < 9; i++) filt_snap_r[i] <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) in_snap_r[i] <= input_bus[i*DW +: DW];
            for (int i = 0; i < 9; i++) filt_snap_r[i] <= filter_bus[i*DW +: DW];
            acc_r   <= '0;
            k_r     <= 4'd0;
            w_r     <= 2'd0;
            busy_r  <= 1'b1;
            state_r <= ST_MAC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MAC: begin
          acc_r <= sum_s;
          if (k_r == 4'd8) begin
            out_data_r  <= sum_s;
            out_idx_r   <= w_r;
            out_valid_r <= 1'b1;
            state_r     <= ST_OUT;
          end else begin
            k_r <= k_r + 4'd1;
          end
        end
        ST_OUT: begin
          // Result is held untouched until the sink takes it
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            if (w_r == 2'd3) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              w_r     <= w_r + 2'd1;
              acc_r   <= '0;
              k_r     <= 4'd0;
              state_r <= ST_MAC;
            end
          end else begin
            state_r <= ST_OUT;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          out_valid_r <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign out_valid = out_valid_r;
  assign done      = done_r;

endmodule

// File: tb/tb_conv_window_reader.sv
// Randomized and directed bench for conv_window_reader against a plain
// arithmetic convolution model.
module tb_conv_window_reader;

  logic           clk;
  logic           rst;
  logic           start;
  logic [127:0]   input_bus;
  logic [71:0]    filter_bus;
  logic           busy;
  logic [19:0]    out_data;
  logic [1:0]     out_idx;
  logic           out_valid;
  logic           out_ready;
  logic           done;

  int n_checks;
  int n_fail;

  int in_b [16];
  int f_b  [9];

  int got_data [8];
  int got_idx  [8];
  int rise_n   [8];
  int nres, ndone, done_n, stable_err, busy0, busy_after;
  bit timed_out;

  conv_window_reader #(.DW(8), .AW(20)) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_bus(input_bus), .filter_bus(filter_bus),
    .busy(busy), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: window w at (w/2, w%2), sum of in[(r+i)][(c+j)] * f[i][j]
  function automatic int model_window(input int w);
    int r0, c0, s;
    r0 = w / 2;
    c0 = w % 2;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += in_b[(r0 + i) * 4 + (c0 + j)] * f_b[i * 3 + j];
    return s;
  endfunction

  task automatic drive_buses();
    for (int i = 0; i < 16; i++) input_bus[i*8 +: 8] = in_b[i][7:0];
    for (int i = 0; i < 9; i++) filter_bus[i*8 +: 8] = f_b[i][7:0];
  endtask

  task automatic load_constants();
    int ci [16] = '{15, 225, 61, 68, 169, 40, 71, 140, 120, 9, 253, 246, 12, 151, 232, 234};
    int cf [9]  = '{175, 196, 212, 117, 241, 69, 9, 255, 188};
    for (int i = 0; i < 16; i++) in_b[i] = ci[i];
    for (int i = 0; i < 9; i++) f_b[i] = cf[i];
    drive_buses();
  endtask

  // Pulse start, then observe one run cycle by cycle; n counts edges after E0
  task automatic run_collect(input int stall, input bit corrupt, input bit extra_start);
    int stall_left, held_data, held_idx;
    bit prev_valid, prev_ready;
    nres = 0; ndone = 0; done_n = -1; stable_err = 0; busy0 = -1; busy_after = -1;
    timed_out = 1'b1; stall_left = 0; held_data = 0; held_idx = 0;
    prev_valid = 1'b0; prev_ready = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n == 0) busy0 = busy;
      if (corrupt && n == 0) begin input_bus = '1; filter_bus = '1; end
      if (extra_start) start = (n == 3);
      if (done) begin ndone++; done_n = n; end
      if (done_n >= 0 && n == done_n + 1) busy_after = busy;
      if (out_valid) begin
        if (!prev_valid) begin
          if (nres < 8) begin
            got_data[nres] = out_data; got_idx[nres] = out_idx; rise_n[nres] = n;
          end
          nres++;
          stall_left = stall;
        end else begin
          if (out_data !== held_data[19:0] || out_idx !== held_idx[1:0]) stable_err++;
          if (stall_left > 0) stall_left--;
        end
        held_data = out_data;
        held_idx = out_idx;
        out_ready = (stall_left == 0);
      end else begin
        if (prev_valid && !prev_ready) stable_err++;
        out_ready = 1'b1;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      if (done_n >= 0 && n == done_n + 4) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b want=0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", busy); end
    n_checks++; if (out_data !== 20'd0) begin n_fail++; $display("FAIL reset_data got=%0d want=0", out_data); end
    n_checks++; if (out_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got=%0d want=0", out_idx); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_memory_constants();
    int exp_v [4] = '{144908, 208042, 168362, 234107};
    load_constants();
    run_collect(0, 1'b0, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL const_timeout got=1 want=0"); end
    n_checks++; if (nres !== 4) begin n_fail++; $display("FAIL const_count got=%0d want=4", nres); end
    n_checks++; if (busy0 !== 1) begin n_fail++; $display("FAIL const_busy_rise got=%0d want=1", busy0); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_data[i] !== exp_v[i]) begin n_fail++; $display("FAIL const_data%0d got=%0d want=%0d", i, got_data[i], exp_v[i]); end
      n_checks++; if (got_idx[i] !== i) begin n_fail++; $display("FAIL const_idx%0d got=%0d want=%0d", i, got_idx[i], i); end
      n_checks++; if (rise_n[i] !== 9 + 10 * i) begin n_fail++; $display("FAIL const_timing%0d got=%0d want=%0d", i, rise_n[i], 9 + 10 * i); end
    end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL const_done_count got=%0d want=1", ndone); end
    n_checks++; if (done_n !== 40) begin n_fail++; $display("FAIL const_done_time got=%0d want=40", done_n); end
    n_checks++; if (busy_after !== 0) begin n_fail++; $display("FAIL const_busy_fall got=%0d want=0", busy_after); end
  endtask

  task automatic test_backpressure();
    load_constants();
    run_collect(5, 1'b0, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout got=1 want=0"); end
    n_checks++; if (nres !== 4) begin n_fail++; $display("FAIL bp_count got=%0d want=4", nres); end
    n_checks++; if (stable_err !== 0) begin n_fail++; $display("FAIL bp_stability got=%0d want=0", stable_err); end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL bp_done_count got=%0d want=1", ndone); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_data[i] !== model_window(i)) begin n_fail++; $display("FAIL bp_data%0d got=%0d want=%0d", i, got_data[i], model_window(i)); end
      n_checks++; if (got_idx[i] !== i) begin n_fail++; $display("FAIL bp_idx%0d got=%0d want=%0d", i, got_idx[i], i); end
    end
  endtask

  task automatic test_max_width();
    for (int i = 0; i < 16; i++) in_b[i] = 255;
    for (int i = 0; i < 9; i++) f_b[i] = 255;
    drive_buses();
    run_collect(1, 1'b0, 1'b0);
    n_checks++; if (nres !== 4) begin n_fail++; $display("FAIL max_count got=%0d want=4", nres); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_data[i] !== 585225) begin n_fail++; $display("FAIL max_data%0d got=%0d want=585225", i, got_data[i]); end
    end
  endtask

  task automatic test_snapshot_ignored_start();
    load_constants();
    run_collect(0, 1'b1, 1'b1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL snap_timeout got=1 want=0"); end
    n_checks++; if (nres !== 4) begin n_fail++; $display("FAIL snap_count got=%0d want=4", nres); end
    n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL snap_done_count got=%0d want=1", ndone); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL snap_idle_after got=%0b want=0", busy); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_data[i] !== model_window(i)) begin n_fail++; $display("FAIL snap_data%0d got=%0d want=%0d", i, got_data[i], model_window(i)); end
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 4; run++) begin
      for (int i = 0; i < 16; i++) in_b[i] = $urandom_range(0, 255);
      for (int i = 0; i < 9; i++) f_b[i] = $urandom_range(0, 255);
      drive_buses();
      run_collect($urandom_range(0, 3), 1'b0, 1'b0);
      n_checks++; if (nres !== 4) begin n_fail++; $display("FAIL rand%0d_count got=%0d want=4", run, nres); end
      n_checks++; if (stable_err !== 0) begin n_fail++; $display("FAIL rand%0d_stability got=%0d want=0", run, stable_err); end
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (got_data[i] !== model_window(i)) begin n_fail++; $display("FAIL rand%0d_data%0d got=%0d want=%0d", run, i, got_data[i], model_window(i)); end
        n_checks++; if (got_idx[i] !== i) begin n_fail++; $display("FAIL rand%0d_idx%0d got=%0d want=%0d", run, i, got_idx[i], i); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int stray;
    load_constants();
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // After E12; window 1's third MAC edge is E13, where reset is sampled
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%0b want=0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%0b want=0", out_valid); end
    n_checks++; if (out_data !== 20'd0) begin n_fail++; $display("FAIL mid_data got=%0d want=0", out_data); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done got=%0b want=0", done); end
    rst = 1'b1;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL mid_stays_idle got=%0d want=0", stray); end
    run_collect(0, 1'b0, 1'b0);
    n_checks++; if (nres !== 4) begin n_fail++; $display("FAIL mid_restart_count got=%0d want=4", nres); end
    n_checks++; if (got_data[0] !== 144908) begin n_fail++; $display("FAIL mid_restart_first got=%0d want=144908", got_data[0]); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    input_bus = '0;
    filter_bus = '0;
    test_reset();
    test_memory_constants();
    test_backpressure();
    test_max_width();
    test_snapshot_ignored_start();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
